// File: rtl/fmrv32im_plic_prio.sv
// fmrv32im_plic_prio: prioritised interrupt controller with threshold, per-source
// level/edge gateways and a claim/complete handshake on the local peripheral bus.
module fmrv32im_plic_prio #(
    parameter int NUM_SRC = 32,
    parameter int PRIO_W  = 3,
    parameter int ADDR_W  = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               BUS_WE,
    input  logic               BUS_RE,
    input  logic [ADDR_W-1:0]  BUS_ADDR,
    input  logic [31:0]        BUS_WDATA,
    output logic [31:0]        BUS_RDATA,
    input  logic [NUM_SRC-1:0] INT_IN,
    output logic               INT_OUT
);

    localparam int ID_W = $clog2(NUM_SRC + 1);

    localparam logic [ADDR_W-1:0] ADDR_PENDING   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_ENABLE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MODE      = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_THRESHOLD = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_CLAIM     = ADDR_W'(4);
    localparam int                PRIO_BASE      = 8;

    logic [NUM_SRC-1:0] sync1_q, sync1_d;
    logic [NUM_SRC-1:0] sync2_q, sync2_d;
    logic [NUM_SRC-1:0] sync2_dly_q, sync2_dly_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [NUM_SRC-1:0] insvc_q, insvc_d;
    logic [PRIO_W-1:0]  threshold_q, threshold_d;
    logic [PRIO_W-1:0]  prio_q [NUM_SRC];
    logic [PRIO_W-1:0]  prio_d [NUM_SRC];
    logic [ID_W-1:0]    best_id_q, best_id_d;
    logic [PRIO_W-1:0]  best_prio_q, best_prio_d;
    logic               int_out_q, int_out_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] level_set;
    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] claim_mask;
    logic [ID_W-1:0]    claim_id;
    logic [ID_W-1:0]    cand_id;
    logic [PRIO_W-1:0]  cand_prio;
    logic               rd_en;
    logic               claim_en;

    // A simultaneous write wins over a read, so the read (and its claim) is dropped.
    assign rd_en     = BUS_RE & ~BUS_WE;
    assign claim_en  = rd_en && (BUS_ADDR == ADDR_CLAIM);
    // Only a delivered interrupt can be claimed; otherwise the claim returns ID 0.
    assign claim_id  = int_out_q ? best_id_q : '0;

    assign edge_det  = sync2_q & ~sync2_dly_q;
    assign level_set = ~mode_q & sync2_q & ~insvc_q;
    assign edge_set  = mode_q & edge_det;

    // Decode the claimed ID into a one-hot source mask.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        claim_mask = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            claim_mask[s] = claim_en && (claim_id == ID_W'(s + 1));
        end
    end

    // Arbitration: highest priority among eligible sources; strict '>' keeps the lowest ID on ties.
    always_comb begin
        cand_id   = '0;
        cand_prio = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (pending_q[s] && enable_q[s] && !insvc_q[s] && (prio_q[s] > cand_prio)) begin
                cand_id   = ID_W'(s + 1);
                cand_prio = prio_q[s];
            end
        end
    end

    // Next-state logic: synchronisers, gateways, bus writes/reads and the registered arbiter result.
    always_comb begin
        sync1_d     = INT_IN;
        sync2_d     = sync1_q;
        sync2_dly_d = sync2_q;
        enable_d    = enable_q;
        mode_d      = mode_q;
        threshold_d = threshold_q;
        prio_d      = prio_q;
        rdata_d     = rdata_q;

        // A claim clears pending, but a fresh edge on the same source in the same cycle is kept.
        pending_d = ((pending_q | level_set) & ~claim_mask) | edge_set;
        insvc_d   = insvc_q | claim_mask;

        if (BUS_WE) begin
            case (BUS_ADDR)
                ADDR_PENDING:   ;
                ADDR_ENABLE:    enable_d    = BUS_WDATA[NUM_SRC-1:0];
                ADDR_MODE:      mode_d      = BUS_WDATA[NUM_SRC-1:0];
                ADDR_THRESHOLD: threshold_d = BUS_WDATA[PRIO_W-1:0];
                ADDR_CLAIM: begin
                    for (int s = 0; s < NUM_SRC; s++) begin
                        if (BUS_WDATA == 32'(s + 1)) insvc_d[s] = 1'b0;
                    end
                end
                default: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (BUS_ADDR == ADDR_W'(PRIO_BASE + i)) prio_d[i] = BUS_WDATA[PRIO_W-1:0];
                    end
                end
            endcase
        end

        if (rd_en) begin
            rdata_d = '0;
            case (BUS_ADDR)
                ADDR_PENDING:   rdata_d = 32'(pending_q);
                ADDR_ENABLE:    rdata_d = 32'(enable_q);
                ADDR_MODE:      rdata_d = 32'(mode_q);
                ADDR_THRESHOLD: rdata_d = 32'(threshold_q);
                ADDR_CLAIM:     rdata_d = 32'(claim_id);
                default: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (BUS_ADDR == ADDR_W'(PRIO_BASE + i)) rdata_d = 32'(prio_q[i]);
                    end
                end
            endcase
        end

        // The claim edge blanks the request so the same ID cannot be claimed twice back-to-back.
        if (claim_en) begin
            best_id_d   = '0;
            best_prio_d = '0;
            int_out_d   = 1'b0;
        end else begin
            best_id_d   = cand_id;
            best_prio_d = cand_prio;
            int_out_d   = cand_prio > threshold_q;
        end
    end

    // State register with asynchronous reset of every flop, including the priority table.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync2_dly_q <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            mode_q      <= '0;
            insvc_q     <= '0;
            threshold_q <= '0;
            // NOTE: the priority array is reset explicitly; an unreset table would deliver garbage priorities.
            for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
            best_id_q   <= '0;
            best_prio_q <= '0;
            int_out_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync2_dly_q <= sync2_dly_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            insvc_q     <= insvc_d;
            threshold_q <= threshold_d;
            for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= prio_d[i];
            best_id_q   <= best_id_d;
            best_prio_q <= best_prio_d;
            int_out_q   <= int_out_d;
            rdata_q     <= rdata_d;
        end
    end

    assign BUS_RDATA = rdata_q;
    assign INT_OUT   = int_out_q;

endmodule

// File: tb/tb_fmrv32im_plic_prio.sv
// Self-checking bench for fmrv32im_plic_prio: register table plus hand-written interrupt sequences.
module tb_fmrv32im_plic_prio;

    logic        clk;
    logic        rst;
    logic        bus_we;
    logic        bus_re;
    logic [5:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [31:0] bus_rdata8;
    logic [31:0] int_in;
    logic [7:0]  int_in8;
    logic        int_out;
    logic        int_out8;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [31:0] value;
        bit          from8;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } reg_vec_t;

    reg_vec_t vecs[9];

    fmrv32im_plic_prio #(.NUM_SRC(32), .PRIO_W(3), .ADDR_W(6)) u_dut (
        .CLK       (clk),
        .RST       (rst),
        .BUS_WE    (bus_we),
        .BUS_RE    (bus_re),
        .BUS_ADDR  (bus_addr),
        .BUS_WDATA (bus_wdata),
        .BUS_RDATA (bus_rdata),
        .INT_IN    (int_in),
        .INT_OUT   (int_out)
    );

    fmrv32im_plic_prio #(.NUM_SRC(8), .PRIO_W(3), .ADDR_W(6)) u_dut8 (
        .CLK       (clk),
        .RST       (rst),
        .BUS_WE    (bus_we),
        .BUS_RE    (bus_re),
        .BUS_ADDR  (bus_addr),
        .BUS_WDATA (bus_wdata),
        .BUS_RDATA (bus_rdata8),
        .INT_IN    (int_in8),
        .INT_OUT   (int_out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input logic exp);
        check(name, {31'b0, int_out}, {31'b0, exp});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [5:0] addr, input logic [31:0] data);
        bus_we    = 1'b1;
        bus_addr  = addr;
        bus_wdata = data;
        @(negedge clk);
        bus_we    = 1'b0;
    endtask

    // Expected read data is queued at drive time and retired when the registered data appears.
    task automatic bus_read(input logic [5:0] addr, input logic [31:0] exp, input string name,
                            input bit from8 = 1'b0);
        exp_t e;
        exp_q.push_back('{name, exp, from8});
        bus_re   = 1'b1;
        bus_addr = addr;
        @(negedge clk);
        bus_re   = 1'b0;
        e = exp_q.pop_front();
        check(e.name, e.from8 ? bus_rdata8 : bus_rdata, e.value);
    endtask

    task automatic bus_write_read(input logic [5:0] addr, input logic [31:0] data,
                                  input logic [31:0] hold, input string name);
        exp_t e;
        exp_q.push_back('{name, hold, 1'b0});
        bus_we    = 1'b1;
        bus_re    = 1'b1;
        bus_addr  = addr;
        bus_wdata = data;
        @(negedge clk);
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        e = exp_q.pop_front();
        check(e.name, bus_rdata, e.value);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        int_in = '0;
        idle(2);
        rst    = 1'b0;
        idle(1);
    endtask

    initial begin
        rst       = 1'b1;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        int_in    = '0;
        int_in8   = '0;
        idle(2);
        check("reset_rdata", bus_rdata, 32'h0);
        check_int("reset_int_out", 1'b0);
        check("reset_rdata8", bus_rdata8, 32'h0);
        rst = 1'b0;
        idle(1);

        // Register map: write then read back.
        vecs[0] = '{6'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "reg_enable"};
        vecs[1] = '{6'h02, 32'hA5A5_5A5A, 32'hA5A5_5A5A, "reg_mode"};
        vecs[2] = '{6'h03, 32'hFFFF_FFFF, 32'h0000_0007, "reg_threshold_mask"};
        vecs[3] = '{6'h08, 32'h0000_00FD, 32'h0000_0005, "reg_prio1_mask"};
        vecs[4] = '{6'h27, 32'h0000_0006, 32'h0000_0006, "reg_prio32"};
        vecs[5] = '{6'h28, 32'h0000_0007, 32'h0000_0000, "reg_unmapped_28"};
        vecs[6] = '{6'h00, 32'hFFFF_FFFF, 32'h0000_0000, "reg_pending_ro"};
        vecs[7] = '{6'h05, 32'h0000_1234, 32'h0000_0000, "reg_unmapped_05"};
        vecs[8] = '{6'h07, 32'h0000_0001, 32'h0000_0000, "reg_unmapped_07"};
        for (int i = 0; i < 9; i++) begin
            bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        bus_read(6'h03, 32'h7, "rw_pre");
        bus_write_read(6'h03, 32'h2, 32'h7, "rw_hold");
        bus_read(6'h03, 32'h2, "rw_written");

        // Level source ID 3: latency, claim, blocked while in service, complete re-delivers.
        do_reset();
        bus_write(6'h0A, 32'd2);
        bus_write(6'h01, 32'h4);
        bus_write(6'h02, 32'h0);
        bus_write(6'h03, 32'h0);
        int_in[2] = 1'b1;
        idle(3);
        check_int("t1_int_edge3", 1'b0);
        idle(1);
        check_int("t1_int_edge4", 1'b1);
        bus_read(6'h04, 32'd3, "t1_claim");
        check_int("t1_int_after_claim", 1'b0);
        idle(4);
        check_int("t1_int_insvc", 1'b0);
        bus_read(6'h00, 32'h0, "t1_pending_insvc");
        bus_write(6'h04, 32'd3);
        idle(1);
        check_int("t1_int_complete_p1", 1'b0);
        idle(1);
        check_int("t1_int_complete_p2", 1'b1);

        // Priority order with tie broken by lowest ID.
        do_reset();
        bus_write(6'h08, 32'd5);
        bus_write(6'h09, 32'd5);
        bus_write(6'h0B, 32'd6);
        bus_write(6'h01, 32'hB);
        int_in = 32'hB;
        idle(6);
        bus_read(6'h04, 32'd4, "t2_claim_4");
        int_in[3] = 1'b0;
        idle(4);
        bus_write(6'h04, 32'd4);
        bus_read(6'h04, 32'd1, "t2_claim_1");
        int_in[0] = 1'b0;
        idle(4);
        bus_write(6'h04, 32'd1);
        bus_read(6'h04, 32'd2, "t2_claim_2");

        // Threshold gating.
        do_reset();
        bus_write(6'h08, 32'd5);
        bus_write(6'h01, 32'h1);
        bus_write(6'h03, 32'd5);
        int_in[0] = 1'b1;
        idle(6);
        check_int("t3_int_thr5", 1'b0);
        bus_read(6'h00, 32'h1, "t3_pending");
        bus_read(6'h04, 32'd0, "t3_claim_none");
        bus_write(6'h03, 32'd4);
        check_int("t3_int_thr4_edge0", 1'b0);
        idle(1);
        check_int("t3_int_thr4_edge1", 1'b1);
        bus_read(6'h04, 32'd1, "t3_claim_1");

        // Edge mode: an edge while in service is held and re-delivered after complete.
        do_reset();
        bus_write(6'h09, 32'd3);
        bus_write(6'h01, 32'h2);
        bus_write(6'h02, 32'h2);
        int_in[1] = 1'b1;
        idle(2);
        int_in[1] = 1'b0;
        idle(5);
        check_int("t4_int_first", 1'b1);
        bus_read(6'h04, 32'd2, "t4_claim_first");
        int_in[1] = 1'b1;
        idle(2);
        int_in[1] = 1'b0;
        idle(5);
        check_int("t4_int_insvc", 1'b0);
        bus_read(6'h00, 32'h2, "t4_pending_held");
        bus_write(6'h04, 32'd2);
        check_int("t4_int_complete_edge", 1'b0);
        idle(1);
        check_int("t4_int_redeliver", 1'b1);
        bus_read(6'h04, 32'd2, "t4_claim_second");

        // Claim of ID 6 on the same edge its new input edge is registered.
        do_reset();
        bus_write(6'h0D, 32'd1);
        bus_write(6'h01, 32'h20);
        bus_write(6'h02, 32'h20);
        int_in[5] = 1'b1;
        idle(2);
        int_in[5] = 1'b0;
        idle(5);
        check_int("t5_int_first", 1'b1);
        int_in[5] = 1'b1;
        idle(2);
        bus_read(6'h04, 32'd6, "t5_claim_collide");
        idle(4);
        check_int("t5_int_insvc", 1'b0);
        bus_read(6'h00, 32'h20, "t5_pending_kept");
        bus_write(6'h04, 32'd6);
        idle(1);
        check_int("t5_int_redeliver", 1'b1);
        bus_read(6'h04, 32'd6, "t5_claim_again");

        // Asynchronous reset in the middle of service.
        do_reset();
        bus_write(6'h08, 32'd1);
        bus_write(6'h0A, 32'd2);
        bus_write(6'h01, 32'h5);
        int_in = 32'h5;
        idle(6);
        bus_read(6'h04, 32'd3, "t6_claim_3");
        idle(2);
        check_int("t6_int_other", 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_int("t6_async_int", 1'b0);
        check("t6_async_rdata", bus_rdata, 32'h0);
        @(negedge clk);
        int_in = '0;
        rst    = 1'b0;
        bus_read(6'h00, 32'h0, "t6_pending_rst");
        bus_read(6'h01, 32'h0, "t6_enable_rst");
        bus_read(6'h02, 32'h0, "t6_mode_rst");
        bus_read(6'h03, 32'h0, "t6_threshold_rst");
        bus_read(6'h08, 32'h0, "t6_prio1_rst");
        bus_read(6'h0A, 32'h0, "t6_prio3_rst");

        // Completes with out-of-range IDs do nothing.
        bus_write(6'h08, 32'd1);
        bus_write(6'h01, 32'h1);
        int_in[0] = 1'b1;
        idle(6);
        bus_read(6'h04, 32'd1, "t6_claim_1");
        bus_write(6'h04, 32'd0);
        bus_write(6'h04, 32'd33);
        bus_write(6'h04, 32'd40);
        idle(3);
        check_int("t6_int_bad_complete", 1'b0);
        bus_write(6'h04, 32'd1);
        idle(2);
        check_int("t6_int_good_complete", 1'b1);

        // Narrow build masks ENABLE to NUM_SRC bits.
        bus_write(6'h01, 32'hFFFF);
        bus_read(6'h01, 32'hFF, "t6_enable_num8", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
